mt_decode_stage: RTL and testbench
==================================

MT_DECODE_STAGE -- requirements
Module: mt_decode_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 64: register data width in bits.
REQ-002 Parameter REG_INDEX_BITS, default 5: registers per thread = 2^REG_INDEX_BITS.
REQ-003 Parameter THREAD_INDEX_BITS, default 3: hardware threads = 2^THREAD_INDEX_BITS.
REQ-004 Parameter INSTR_WIDTH, default 32: instruction width in bits.
REQ-005 Parameter IMMEDIATE_WIDTH, default 16: immediate field width in bits.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  upstream instruction valid.
REQ-009 in_instruction  input  INSTR_WIDTH  instruction word.
REQ-010 in_thread_index  input  THREAD_INDEX_BITS  issuing thread.
REQ-011 out_ready  output  1  stage accepts the instruction this cycle.
REQ-012 in_write_back_enable_flag  input  1  write-back strobe.
REQ-013 in_write_back_thread_index  input  THREAD_INDEX_BITS  write-back thread.
REQ-014 in_write_back_reg_index  input  REG_INDEX_BITS  write-back register.
REQ-015 in_write_back_data  input  DATA_WIDTH  write-back value.
REQ-016 out_valid  output  1  decoded bundle valid.
REQ-017 in_downstream_ready  input  1  downstream accepts the bundle.
REQ-018 out_increment_flag, out_load_word_flag, out_store_word_flag, out_illegal_flag  output  1 each  decoded opcode class.
REQ-019 out_reg_index  output  REG_INDEX_BITS; out_thread_index  output  THREAD_INDEX_BITS; out_immediate  output  IMMEDIATE_WIDTH; out_reg_data  output  DATA_WIDTH.
REQ-020 out_stall_count  output  16  count of hazard-stall cycles, saturating.

Function
REQ-021 Fields: opcode = instr[5:0], reg = instr[5+REG_INDEX_BITS:6], immediate = instr[INSTR_WIDTH-1:INSTR_WIDTH-IMMEDIATE_WIDTH].
REQ-022 Opcodes: 000001 increment, 000010 load, 000011 store; any other opcode sets only out_illegal_flag.
REQ-023 Register file is 2^(THREAD+REG) x DATA_WIDTH, addressed {thread, reg}, internal; read is combinational; write on clk when the write-back strobe is high.
REQ-024 Read bypass: write-back to the same {thread, reg} in the accept cycle returns in_write_back_data.
REQ-025 Scoreboard: one busy bit per {thread, reg}.
REQ-026 Increment and store read reg; increment and load write reg.
REQ-027 Hazard: in_valid high and the busy bit for {in_thread_index, reg} set, not cleared by a write-back this cycle; illegal opcodes never hazard.
REQ-028 out_ready = !hazard && (!out_valid || in_downstream_ready).
REQ-029 Accept = in_valid && out_ready.
REQ-030 On accept, all outputs register next edge and out_valid becomes 1; latency is exactly 1 cycle.
REQ-031 On accept of increment or load, the destination busy bit is set.
REQ-032 Write-back strobe clears the busy bit of its address.
REQ-033 If a write-back clear and an accept set target the same entry in one edge, set wins.
REQ-034 If out_valid && !in_downstream_ready, all outputs hold stable.
REQ-035 If out_valid && in_downstream_ready && !accept, out_valid drops next edge.
REQ-036 Threads are independent: a hazard in thread A does not stall thread B except through the shared single input port.
REQ-037 out_stall_count increments each cycle in_valid && hazard, and saturates at 16'hFFFF.

Reset
REQ-038 While rst is high at an edge: out_valid = 0, all flags = 0, out_reg_index/out_thread_index/out_immediate/out_reg_data = 0, scoreboard cleared, out_stall_count = 0.
REQ-039 Register file contents are not reset; write-backs during rst are ignored; out_ready = 0 while rst is high.
REQ-040 Reset asserted mid-stall or mid-backpressure discards the held bundle and all pending busy bits.

Verification
REQ-041 Write-back t2 r5 = 0x1234, then issue store r5 on t2 with downstream ready -> next cycle out_valid = 1, out_store_word_flag = 1, out_reg_data = 0x1234, out_thread_index = 2.
REQ-042 Load r3 on t0, then increment r3 on t0 -> out_ready = 0 for 4 cycles; out_stall_count = 4. Write-back t0 r3 = 7 in cycle 5 -> accepted that cycle with out_reg_data = 7 via bypass.
REQ-043 Load r3 on t0 busy, then increment r3 on t1 -> accepted without stall.
REQ-044 in_downstream_ready = 0 for 3 cycles with a bundle held -> outputs stable, out_ready = 0. Ready raised with a new in_valid -> back-to-back transfer, one per cycle.
REQ-045 Opcode 111111 -> out_illegal_flag = 1, other flags 0, no busy bit set.
REQ-046 Assert rst during a stall -> out_valid = 0 and scoreboard clear. After rst releases, the previously stalled instruction is accepted immediately.

Source files
------------

// File: rtl/mt_decode_stage_if.sv
// Handshake and data bundle for the multithreaded decode stage.
// The master drives requests and write-backs; the slave (the decode stage) returns the decoded bundle.
interface mt_decode_stage_if #(
  parameter int DATA_WIDTH        = 64,
  parameter int REG_INDEX_BITS    = 5,
  parameter int THREAD_INDEX_BITS = 3,
  parameter int INSTR_WIDTH       = 32,
  parameter int IMMEDIATE_WIDTH   = 16
);
  logic                         in_valid;
  logic [INSTR_WIDTH-1:0]       in_instruction;
  logic [THREAD_INDEX_BITS-1:0] in_thread_index;
  logic                         out_ready;
  logic                         in_write_back_enable_flag;
  logic [THREAD_INDEX_BITS-1:0] in_write_back_thread_index;
  logic [REG_INDEX_BITS-1:0]    in_write_back_reg_index;
  logic [DATA_WIDTH-1:0]        in_write_back_data;
  logic                         out_valid;
  logic                         in_downstream_ready;
  logic                         out_increment_flag;
  logic                         out_load_word_flag;
  logic                         out_store_word_flag;
  logic                         out_illegal_flag;
  logic [REG_INDEX_BITS-1:0]    out_reg_index;
  logic [THREAD_INDEX_BITS-1:0] out_thread_index;
  logic [IMMEDIATE_WIDTH-1:0]   out_immediate;
  logic [DATA_WIDTH-1:0]        out_reg_data;
  logic [15:0]                  out_stall_count;

  modport master (
    output in_valid, in_instruction, in_thread_index,
    output in_write_back_enable_flag, in_write_back_thread_index,
    output in_write_back_reg_index, in_write_back_data, in_downstream_ready,
    input  out_ready, out_valid, out_increment_flag, out_load_word_flag,
    input  out_store_word_flag, out_illegal_flag, out_reg_index, out_thread_index,
    input  out_immediate, out_reg_data, out_stall_count
  );

  modport slave (
    input  in_valid, in_instruction, in_thread_index,
    input  in_write_back_enable_flag, in_write_back_thread_index,
    input  in_write_back_reg_index, in_write_back_data, in_downstream_ready,
    output out_ready, out_valid, out_increment_flag, out_load_word_flag,
    output out_store_word_flag, out_illegal_flag, out_reg_index, out_thread_index,
    output out_immediate, out_reg_data, out_stall_count
  );
endinterface

// File: rtl/mt_decode_stage.sv
// Multithreaded decode stage: opcode decode, per-thread register file read with write-back
// bypass, and a per-{thread,reg} busy scoreboard that stalls instructions on pending writes.
module mt_decode_stage #(
  parameter int DATA_WIDTH        = 64,
  parameter int REG_INDEX_BITS    = 5,
  parameter int THREAD_INDEX_BITS = 3,
  parameter int INSTR_WIDTH       = 32,
  parameter int IMMEDIATE_WIDTH   = 16
) (
  input logic              clk,
  input logic              rst,
  mt_decode_stage_if.slave bus
);
  localparam int ADDR_BITS = THREAD_INDEX_BITS + REG_INDEX_BITS;
  localparam int ENTRIES   = 1 << ADDR_BITS;

  localparam logic [5:0] OP_INCREMENT = 6'b000001;
  localparam logic [5:0] OP_LOAD      = 6'b000010;
  localparam logic [5:0] OP_STORE     = 6'b000011;

  logic [DATA_WIDTH-1:0]      reg_file [ENTRIES];
  logic [ENTRIES-1:0]         busy;

  logic [5:0]                 opcode;
  logic [REG_INDEX_BITS-1:0]  dec_reg;
  logic [IMMEDIATE_WIDTH-1:0] dec_imm;
  logic [ADDR_BITS-1:0]       rd_addr;
  logic [ADDR_BITS-1:0]       wb_addr;
  logic                       is_increment;
  logic                       is_load;
  logic                       is_store;
  logic                       is_illegal;
  logic                       writes_reg;
  logic                       wb_active;
  logic                       wb_hit;
  logic                       hazard;
  logic                       accept;
  logic [DATA_WIDTH-1:0]      read_data;
  logic                       unused_instr_bits;

  assign opcode            = bus.in_instruction[5:0];
  assign dec_reg           = bus.in_instruction[5+REG_INDEX_BITS:6];
  assign dec_imm           = bus.in_instruction[INSTR_WIDTH-1:INSTR_WIDTH-IMMEDIATE_WIDTH];
  assign unused_instr_bits = ^bus.in_instruction;
  assign rd_addr           = {bus.in_thread_index, dec_reg};
  assign wb_addr           = {bus.in_write_back_thread_index, bus.in_write_back_reg_index};

  always_comb begin
    is_increment = 1'b0;
    is_load      = 1'b0;
    is_store     = 1'b0;
    is_illegal   = 1'b0;
    case (opcode)
      OP_INCREMENT: is_increment = 1'b1;
      OP_LOAD:      is_load      = 1'b1;
      OP_STORE:     is_store     = 1'b1;
      default:      is_illegal   = 1'b1;
    endcase
  end

  // Write-backs are ignored during reset, so they neither write nor clear busy bits.
  assign wb_active  = bus.in_write_back_enable_flag && !rst;
  assign wb_hit     = wb_active && (wb_addr == rd_addr);
  assign writes_reg = is_increment || is_load;
  assign hazard     = bus.in_valid && !is_illegal && busy[rd_addr] && !wb_hit;
  assign read_data  = wb_hit ? bus.in_write_back_data : reg_file[rd_addr];

  assign bus.out_ready = !rst && !hazard && (!bus.out_valid || bus.in_downstream_ready);
  assign accept        = bus.in_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (wb_active) reg_file[wb_addr] <= bus.in_write_back_data;
  end

  // The accept-side set is written last so it wins over a same-edge write-back clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wb_active) busy[wb_addr] <= 1'b0;
      if (accept && writes_reg) busy[rd_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_stall_count <= '0;
    end else if (hazard && bus.out_stall_count != 16'hFFFF) begin
      bus.out_stall_count <= bus.out_stall_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid           <= 1'b0;
      bus.out_increment_flag  <= 1'b0;
      bus.out_load_word_flag  <= 1'b0;
      bus.out_store_word_flag <= 1'b0;
      bus.out_illegal_flag    <= 1'b0;
      bus.out_reg_index       <= '0;
      bus.out_thread_index    <= '0;
      bus.out_immediate       <= '0;
      bus.out_reg_data        <= '0;
    end else if (accept) begin
      bus.out_valid           <= 1'b1;
      bus.out_increment_flag  <= is_increment;
      bus.out_load_word_flag  <= is_load;
      bus.out_store_word_flag <= is_store;
      bus.out_illegal_flag    <= is_illegal;
      bus.out_reg_index       <= dec_reg;
      bus.out_thread_index    <= bus.in_thread_index;
      bus.out_immediate       <= dec_imm;
      bus.out_reg_data        <= read_data;
    end else if (bus.out_valid && bus.in_downstream_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mt_decode_stage.sv
// Directed-vector bench for mt_decode_stage: decode, bypass, hazard stalls, backpressure and reset.
module tb_mt_decode_stage;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mt_decode_stage_if bus ();

  mt_decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] OP_INC   = 6'd1;
  localparam logic [5:0] OP_LOAD  = 6'd2;
  localparam logic [5:0] OP_STORE = 6'd3;
  localparam logic [5:0] OP_BAD   = 6'h3F;

  function automatic logic [31:0] mk(input logic [15:0] imm, input logic [4:0] r, input logic [5:0] op);
    return {imm, 5'b0, r, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr(input logic valid, input logic [2:0] thread, input logic [31:0] instr);
    bus.in_valid        = valid;
    bus.in_thread_index = thread;
    bus.in_instruction  = instr;
  endtask

  task automatic drive_wb(input logic en, input logic [2:0] thread, input logic [4:0] r, input logic [63:0] data);
    bus.in_write_back_enable_flag  = en;
    bus.in_write_back_thread_index = thread;
    bus.in_write_back_reg_index    = r;
    bus.in_write_back_data         = data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_downstream_ready = 1'b1;
    drive_instr(1'b0, 3'd0, 32'd0);
    drive_wb(1'b0, 3'd0, 5'd0, 64'd0);
    tick();
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_stall_count !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_stall got %0d want 0", bus.out_stall_count); end
    vectors++; if ({bus.out_increment_flag, bus.out_load_word_flag, bus.out_store_word_flag, bus.out_illegal_flag} !== 4'b0) begin miscompares++; $display("[TB] FAIL reset_flags got nonzero want 0000"); end
    vectors++; if (bus.out_reg_data !== 64'd0 || bus.out_immediate !== 16'd0 || bus.out_reg_index !== 5'd0 || bus.out_thread_index !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_fields got data %h imm %h want 0", bus.out_reg_data, bus.out_immediate); end
    drive_instr(1'b1, 3'd0, mk(16'h0, 5'd1, OP_INC));
    #1;
    vectors++; if (bus.out_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready got %b want 0", bus.out_ready); end
    drive_instr(1'b0, 3'd0, 32'd0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_store_read();
    drive_wb(1'b1, 3'd2, 5'd5, 64'h1234);
    tick();
    drive_wb(1'b0, 3'd0, 5'd0, 64'd0);
    drive_instr(1'b1, 3'd2, mk(16'hABCD, 5'd5, OP_STORE));
    #1;
    vectors++; if (bus.out_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL store_ready got %b want 1", bus.out_ready); end
    tick();
    drive_instr(1'b0, 3'd0, 32'd0);
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_store_word_flag !== 1'b1) begin miscompares++; $display("[TB] FAIL store_valid got v%b s%b want 1 1", bus.out_valid, bus.out_store_word_flag); end
    vectors++; if (bus.out_increment_flag !== 1'b0 || bus.out_load_word_flag !== 1'b0 || bus.out_illegal_flag !== 1'b0) begin miscompares++; $display("[TB] FAIL store_other_flags got nonzero want 0"); end
    vectors++; if (bus.out_reg_data !== 64'h1234) begin miscompares++; $display("[TB] FAIL store_data got %h want 1234", bus.out_reg_data); end
    vectors++; if (bus.out_thread_index !== 3'd2 || bus.out_reg_index !== 5'd5 || bus.out_immediate !== 16'hABCD) begin miscompares++; $display("[TB] FAIL store_fields got t%0d r%0d imm %h want t2 r5 imm abcd", bus.out_thread_index, bus.out_reg_index, bus.out_immediate); end
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL store_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_hazard();
    drive_instr(1'b1, 3'd0, mk(16'h0003, 5'd3, OP_LOAD));
    tick();
    drive_instr(1'b1, 3'd0, mk(16'h0004, 5'd3, OP_INC));
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (bus.out_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL hazard_ready_%0d got %b want 0", i, bus.out_ready); end
      tick();
    end
    vectors++; if (bus.out_stall_count !== 16'd4) begin miscompares++; $display("[TB] FAIL hazard_stall_count got %0d want 4", bus.out_stall_count); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL hazard_valid_dropped got %b want 0", bus.out_valid); end
    drive_wb(1'b1, 3'd0, 5'd3, 64'd7);
    #1;
    vectors++; if (bus.out_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL hazard_wb_ready got %b want 1", bus.out_ready); end
    tick();
    drive_wb(1'b0, 3'd0, 5'd0, 64'd0);
    drive_instr(1'b0, 3'd0, 32'd0);
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_increment_flag !== 1'b1) begin miscompares++; $display("[TB] FAIL hazard_accept got v%b i%b want 1 1", bus.out_valid, bus.out_increment_flag); end
    vectors++; if (bus.out_reg_data !== 64'd7) begin miscompares++; $display("[TB] FAIL hazard_bypass got %h want 7", bus.out_reg_data); end
    vectors++; if (bus.out_stall_count !== 16'd4) begin miscompares++; $display("[TB] FAIL hazard_count_hold got %0d want 4", bus.out_stall_count); end
    // The increment re-set the busy bit in the same edge the write-back cleared it.
    drive_instr(1'b1, 3'd0, mk(16'h0, 5'd3, OP_LOAD));
    #1;
    vectors++; if (bus.out_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL set_wins_ready got %b want 0", bus.out_ready); end
    drive_instr(1'b0, 3'd0, 32'd0);
    drive_wb(1'b1, 3'd0, 5'd3, 64'd8);
    tick();
    drive_wb(1'b0, 3'd0, 5'd0, 64'd0);
  endtask

  task automatic test_thread_indep();
    drive_instr(1'b1, 3'd0, mk(16'h0, 5'd3, OP_LOAD));
    drive_wb(1'b1, 3'd1, 5'd3, 64'h55);
    #1;
    vectors++; if (bus.out_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL thread_load_ready got %b want 1", bus.out_ready); end
    tick();
    drive_wb(1'b0, 3'd0, 5'd0, 64'd0);
    drive_instr(1'b1, 3'd1, mk(16'h0011, 5'd3, OP_INC));
    #1;
    vectors++; if (bus.out_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL thread_other_ready got %b want 1", bus.out_ready); end
    tick();
    drive_instr(1'b0, 3'd0, 32'd0);
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_increment_flag !== 1'b1 || bus.out_thread_index !== 3'd1) begin miscompares++; $display("[TB] FAIL thread_accept got v%b i%b t%0d want 1 1 t1", bus.out_valid, bus.out_increment_flag, bus.out_thread_index); end
    vectors++; if (bus.out_reg_data !== 64'h55) begin miscompares++; $display("[TB] FAIL thread_data got %h want 55", bus.out_reg_data); end
    drive_wb(1'b1, 3'd0, 5'd3, 64'd9);
    tick();
    drive_wb(1'b0, 3'd0, 5'd0, 64'd0);
  endtask

  task automatic test_back_to_back();
    drive_instr(1'b1, 3'd2, mk(16'h1111, 5'd5, OP_STORE));
    tick();
    bus.in_downstream_ready = 1'b0;
    drive_instr(1'b1, 3'd2, mk(16'h3333, 5'd6, OP_INC));
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (bus.out_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_ready_%0d got %b want 0", i, bus.out_ready); end
      tick();
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_store_word_flag !== 1'b1 || bus.out_immediate !== 16'h1111 || bus.out_reg_data !== 64'h1234) begin miscompares++; $display("[TB] FAIL bp_hold_%0d got v%b s%b imm %h data %h want 1 1 1111 1234", i, bus.out_valid, bus.out_store_word_flag, bus.out_immediate, bus.out_reg_data); end
    end
    bus.in_downstream_ready = 1'b1;
    #1;
    vectors++; if (bus.out_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_ready0 got %b want 1", bus.out_ready); end
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_increment_flag !== 1'b1 || bus.out_immediate !== 16'h3333) begin miscompares++; $display("[TB] FAIL b2b_first got v%b i%b imm %h want 1 1 3333", bus.out_valid, bus.out_increment_flag, bus.out_immediate); end
    drive_instr(1'b1, 3'd2, mk(16'h2222, 5'd7, OP_LOAD));
    #1;
    vectors++; if (bus.out_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_ready1 got %b want 1", bus.out_ready); end
    tick();
    drive_instr(1'b0, 3'd0, 32'd0);
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_load_word_flag !== 1'b1 || bus.out_immediate !== 16'h2222) begin miscompares++; $display("[TB] FAIL b2b_second got v%b l%b imm %h want 1 1 2222", bus.out_valid, bus.out_load_word_flag, bus.out_immediate); end
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_illegal();
    drive_instr(1'b1, 3'd4, mk(16'h0F0F, 5'd9, OP_BAD));
    tick();
    vectors++; if ({bus.out_valid, bus.out_illegal_flag, bus.out_increment_flag, bus.out_load_word_flag, bus.out_store_word_flag} !== 5'b11000) begin miscompares++; $display("[TB] FAIL illegal_flags got %b want 11000", {bus.out_valid, bus.out_illegal_flag, bus.out_increment_flag, bus.out_load_word_flag, bus.out_store_word_flag}); end
    drive_instr(1'b1, 3'd4, mk(16'h0, 5'd9, OP_LOAD));
    #1;
    vectors++; if (bus.out_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL illegal_no_busy got %b want 1", bus.out_ready); end
    tick();
    vectors++; if (bus.out_load_word_flag !== 1'b1 || bus.out_illegal_flag !== 1'b0) begin miscompares++; $display("[TB] FAIL illegal_then_load got l%b x%b want 1 0", bus.out_load_word_flag, bus.out_illegal_flag); end
    drive_instr(1'b1, 3'd4, mk(16'h0, 5'd9, 6'd0));
    #1;
    vectors++; if (bus.out_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL illegal_busy_ready got %b want 1", bus.out_ready); end
    tick();
    drive_instr(1'b0, 3'd0, 32'd0);
    vectors++; if (bus.out_illegal_flag !== 1'b1) begin miscompares++; $display("[TB] FAIL illegal_op0 got %b want 1", bus.out_illegal_flag); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    drive_wb(1'b1, 3'd6, 5'd0, 64'd1);
    tick();
    drive_wb(1'b0, 3'd0, 5'd0, 64'd0);
    drive_instr(1'b1, 3'd3, mk(16'h0, 5'd1, OP_LOAD));
    tick();
    drive_instr(1'b1, 3'd3, mk(16'h0077, 5'd1, OP_INC));
    #1;
    vectors++; if (bus.out_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_stall_ready got %b want 0", bus.out_ready); end
    tick();
    tick();
    vectors++; if (bus.out_stall_count !== 16'd6) begin miscompares++; $display("[TB] FAIL rst_stall_count got %0d want 6", bus.out_stall_count); end
    rst = 1'b1;
    drive_wb(1'b1, 3'd6, 5'd0, 64'hDEAD);
    tick();
    vectors++; if (bus.out_valid !== 1'b0 || bus.out_stall_count !== 16'd0) begin miscompares++; $display("[TB] FAIL rst_mid_clear got v%b cnt %0d want 0 0", bus.out_valid, bus.out_stall_count); end
    vectors++; if (bus.out_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_ready got %b want 0", bus.out_ready); end
    rst = 1'b0;
    drive_wb(1'b0, 3'd0, 5'd0, 64'd0);
    #1;
    vectors++; if (bus.out_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_release_ready got %b want 1", bus.out_ready); end
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_increment_flag !== 1'b1 || bus.out_thread_index !== 3'd3 || bus.out_immediate !== 16'h0077) begin miscompares++; $display("[TB] FAIL rst_release_accept got v%b i%b t%0d imm %h want 1 1 t3 0077", bus.out_valid, bus.out_increment_flag, bus.out_thread_index, bus.out_immediate); end
    drive_instr(1'b1, 3'd6, mk(16'h0, 5'd0, OP_STORE));
    tick();
    drive_instr(1'b0, 3'd0, 32'd0);
    vectors++; if (bus.out_reg_data !== 64'd1) begin miscompares++; $display("[TB] FAIL rst_wb_ignored got %h want 1", bus.out_reg_data); end
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_store_read();
    test_hazard();
    test_thread_indep();
    test_back_to_back();
    test_illegal();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
